// File: rtl/i2s_dma_sched_if.sv
// DMA request/beat handshake between the I2S scheduler and the system DMA.
interface i2s_dma_sched_if #(
  parameter int unsigned BURST_WIDTH = 5
);
  logic                   dma_req_o;
  logic                   dma_dir_o;
  logic [BURST_WIDTH-1:0] dma_len_o;
  logic                   dma_ack_i;
  logic                   dma_beat_i;
  logic                   dma_done_o;
  logic                   dma_abort_o;

  modport master (
    output dma_req_o, dma_dir_o, dma_len_o, dma_done_o, dma_abort_o,
    input  dma_ack_i, dma_beat_i
  );

  modport slave (
    input  dma_req_o, dma_dir_o, dma_len_o, dma_done_o, dma_abort_o,
    output dma_ack_i, dma_beat_i
  );
endinterface

// File: rtl/i2s_dma_sched.sv
// I2S TX/RX FIFO DMA request scheduler: threshold monitoring, round-robin
// arbitration, single outstanding burst with beat tracking, and IRQ flags.
module i2s_dma_sched #(
  parameter int unsigned FIFO_DEPTH     = 64,
  parameter int unsigned LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int unsigned BURST_WIDTH    = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    txie_i,
  input  logic                    rxie_i,
  input  logic [4:0]              tx_th_i,
  input  logic [4:0]              rx_th_i,
  input  logic [BURST_WIDTH-1:0]  burst_len_i,
  input  logic [LOG_FIFO_DEPTH:0] tx_elem_i,
  input  logic [LOG_FIFO_DEPTH:0] rx_elem_i,
  i2s_dma_sched_if.master         dma,
  output logic                    busy_o,
  output logic                    tx_irq_o,
  output logic                    rx_irq_o
);

  localparam int unsigned EW = LOG_FIFO_DEPTH + 1;
  localparam logic [EW-1:0] DEPTH_W = EW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   last_grant_q, last_grant_d;
  logic                   abort_q, abort_d;
  logic                   tx_irq_q, tx_irq_d;
  logic                   rx_irq_q, rx_irq_d;

  logic [BURST_WIDTH-1:0] eff_len;
  logic [EW-1:0]          eff_len_w;
  logic [EW-1:0]          tx_free;
  logic                   run_ok;
  logic                   tx_need;
  logic                   rx_need;
  logic                   abort_req;
  logic                   grant_rx;

  // Service-need evaluation against thresholds and burst fit
  always_comb begin
    eff_len   = (burst_len_i == '0) ? BURST_WIDTH'(1) : burst_len_i;
    eff_len_w = EW'(eff_len);
    tx_free   = DEPTH_W - tx_elem_i;
    run_ok    = en_i & ~flush_i;
    tx_need   = run_ok & (tx_elem_i <= EW'(tx_th_i)) & (tx_free >= eff_len_w);
    rx_need   = run_ok & (rx_elem_i > EW'(rx_th_i)) & (rx_elem_i >= eff_len_w);
    abort_req = flush_i | ~en_i;
    tx_irq_d  = txie_i & en_i & (tx_elem_i <= EW'(tx_th_i));
    rx_irq_d  = rxie_i & en_i & (rx_elem_i > EW'(rx_th_i));
  end

  // Next-state logic: grant, handshake, beat countdown and abort
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    abort_d      = 1'b0;
    grant_rx     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_need | rx_need) begin
          // RX wins only when alone or when TX was served last
          grant_rx = rx_need & (~tx_need | ~last_grant_q);
          dir_d    = grant_rx;
          len_d    = eff_len;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (abort_req) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (dma.dma_ack_i) begin
          state_d = XFER;
          cnt_d   = len_q;
        end
      end
      XFER: begin
        if (abort_req) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (dma.dma_beat_i) begin
          if (cnt_q == BURST_WIDTH'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - BURST_WIDTH'(1);
          end
        end
      end
      DONE: begin
        last_grant_d = dir_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      abort_q      <= 1'b0;
      tx_irq_q     <= 1'b0;
      rx_irq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      abort_q      <= abort_d;
      tx_irq_q     <= tx_irq_d;
      rx_irq_q     <= rx_irq_d;
    end
  end

  assign dma.dma_req_o   = (state_q == REQ);
  assign dma.dma_dir_o   = dir_q;
  assign dma.dma_len_o   = len_q;
  assign dma.dma_done_o  = (state_q == DONE);
  assign dma.dma_abort_o = abort_q;
  assign busy_o          = (state_q != IDLE);
  assign tx_irq_o        = tx_irq_q;
  assign rx_irq_o        = rx_irq_q;

endmodule

// File: tb/tb_i2s_dma_sched.sv
// Directed testbench for i2s_dma_sched.
module tb_i2s_dma_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, flush, txie, rxie;
  logic [4:0] tx_th, rx_th, burst_len;
  logic [6:0] tx_elem, rx_elem;
  logic       busy, tx_irq, rx_irq;
  int         tests = 0;
  int         fails = 0;

  i2s_dma_sched_if #(.BURST_WIDTH(5)) dif ();

  i2s_dma_sched #(.FIFO_DEPTH(64), .BURST_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .txie_i(txie), .rxie_i(rxie), .tx_th_i(tx_th), .rx_th_i(rx_th),
    .burst_len_i(burst_len), .tx_elem_i(tx_elem), .rx_elem_i(rx_elem),
    .dma(dif), .busy_o(busy), .tx_irq_o(tx_irq), .rx_irq_o(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 0; flush = 0; txie = 0; rxie = 0;
    tx_th = 5'd4; rx_th = 5'd31; burst_len = 5'd8;
    tx_elem = 7'd40; rx_elem = 7'd0;
    dif.dma_ack_i = 0; dif.dma_beat_i = 0;
    rst = 1; #2; rst = 0;
  endtask

  task automatic wait_req(input int n, output bit got);
    got = 0;
    for (int i = 0; i < n; i++) begin
      if (dif.dma_req_o === 1'b1) begin got = 1; break; end
      tick();
    end
    if (!got) got = (dif.dma_req_o === 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", dif.dma_req_o); end
    tests++; if (dif.dma_dir_o !== 1'b0) begin fails++; $display("FAIL rst_dir got %b exp 0", dif.dma_dir_o); end
    tests++; if (dif.dma_len_o !== 5'd0) begin fails++; $display("FAIL rst_len got %0d exp 0", dif.dma_len_o); end
    tests++; if (dif.dma_done_o !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", dif.dma_done_o); end
    tests++; if (dif.dma_abort_o !== 1'b0) begin fails++; $display("FAIL rst_abort got %b exp 0", dif.dma_abort_o); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++; if ({tx_irq, rx_irq} !== 2'b00) begin fails++; $display("FAIL rst_irq got %b exp 00", {tx_irq, rx_irq}); end
  endtask

  task automatic test_basic_tx();
    apply_reset();
    en = 1; burst_len = 5'd8; tx_th = 5'd4; tx_elem = 7'd0; rx_th = 5'd31; rx_elem = 7'd0;
    tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL basic_req got %b exp 1", dif.dma_req_o); end
    tests++; if (dif.dma_dir_o !== 1'b0) begin fails++; $display("FAIL basic_dir got %b exp 0", dif.dma_dir_o); end
    tests++; if (dif.dma_len_o !== 5'd8) begin fails++; $display("FAIL basic_len got %0d exp 8", dif.dma_len_o); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
    tx_elem = 7'd40;
    dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
    tests++; if (dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL basic_req_drop got %b exp 0", dif.dma_req_o); end
    dif.dma_beat_i = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++; if (dif.dma_done_o !== 1'b0) begin fails++; $display("FAIL basic_early_done beat %0d got %b exp 0", i + 1, dif.dma_done_o); end
    end
    tick();
    tests++; if (dif.dma_done_o !== 1'b1) begin fails++; $display("FAIL basic_done got %b exp 1", dif.dma_done_o); end
    dif.dma_beat_i = 0;
    tick();
    tests++; if (dif.dma_done_o !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", dif.dma_done_o); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_dir;
    bit got;
    exp_dir = 4'b1010;
    apply_reset();
    en = 1; burst_len = 5'd4; tx_th = 5'd4; tx_elem = 7'd0; rx_th = 5'd2; rx_elem = 7'd40;
    for (int k = 0; k < 4; k++) begin
      wait_req(4, got);
      tests++; if (!got) begin fails++; $display("FAIL rr_req%0d got timeout exp req", k); end
      tests++; if (dif.dma_dir_o !== exp_dir[k]) begin fails++; $display("FAIL rr_dir%0d got %b exp %b", k, dif.dma_dir_o, exp_dir[k]); end
      dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
      dif.dma_beat_i = 1;
      repeat (4) tick();
      dif.dma_beat_i = 0;
      tests++; if (dif.dma_done_o !== 1'b1) begin fails++; $display("FAIL rr_done%0d got %b exp 1", k, dif.dma_done_o); end
    end
    en = 0; tick(); tick();
  endtask

  task automatic test_boundary();
    apply_reset();
    en = 1; burst_len = 5'd8; tx_th = 5'd10; tx_elem = 7'd11; rx_th = 5'd31; rx_elem = 7'd0;
    tick(); tick();
    tests++; if (dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL bnd_tx11 got %b exp 0", dif.dma_req_o); end
    tx_elem = 7'd10; tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL bnd_tx10 got %b exp 1", dif.dma_req_o); end
    tx_elem = 7'd40; en = 0; tick(); en = 1;
    burst_len = 5'd0; tx_elem = 7'd0; tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL bnd_len0_req got %b exp 1", dif.dma_req_o); end
    tests++; if (dif.dma_len_o !== 5'd1) begin fails++; $display("FAIL bnd_len0 got %0d exp 1", dif.dma_len_o); end
    tx_elem = 7'd40;
    dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
    dif.dma_beat_i = 1; tick(); dif.dma_beat_i = 0;
    tests++; if (dif.dma_done_o !== 1'b1) begin fails++; $display("FAIL bnd_len0_done got %b exp 1", dif.dma_done_o); end
    tick();
    rx_th = 5'd2; rx_elem = 7'd3; burst_len = 5'd4;
    tick(); tick();
    tests++; if (dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL bnd_rx3 got %b exp 0", dif.dma_req_o); end
    rx_elem = 7'd4; tick();
    tests++; if (dif.dma_req_o !== 1'b1 || dif.dma_dir_o !== 1'b1) begin fails++; $display("FAIL bnd_rx4 got req=%b dir=%b exp req=1 dir=1", dif.dma_req_o, dif.dma_dir_o); end
    flush = 1; tick(); flush = 0; rx_elem = 7'd0;
    tests++; if (dif.dma_abort_o !== 1'b1) begin fails++; $display("FAIL bnd_req_flush got %b exp 1", dif.dma_abort_o); end
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    en = 1; burst_len = 5'd8; tx_th = 5'd4; tx_elem = 7'd0; rx_th = 5'd31; rx_elem = 7'd0;
    tick();
    tests++; if (dif.dma_req_o !== 1'b1 || dif.dma_dir_o !== 1'b0) begin fails++; $display("FAIL ab_req got req=%b dir=%b exp req=1 dir=0", dif.dma_req_o, dif.dma_dir_o); end
    dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
    dif.dma_beat_i = 1; repeat (3) tick(); dif.dma_beat_i = 0;
    flush = 1; rx_th = 5'd2; rx_elem = 7'd40;
    tick();
    tests++; if (dif.dma_abort_o !== 1'b1) begin fails++; $display("FAIL ab_pulse got %b exp 1", dif.dma_abort_o); end
    tests++; if (dif.dma_done_o !== 1'b0) begin fails++; $display("FAIL ab_nodone got %b exp 0", dif.dma_done_o); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_idle got %b exp 0", busy); end
    flush = 0; tick();
    tests++; if (dif.dma_abort_o !== 1'b0) begin fails++; $display("FAIL ab_pulse_end got %b exp 0", dif.dma_abort_o); end
    tests++; if (dif.dma_req_o !== 1'b1 || dif.dma_dir_o !== 1'b0) begin fails++; $display("FAIL ab_regrant got req=%b dir=%b exp req=1 dir=0", dif.dma_req_o, dif.dma_dir_o); end
    en = 0; tick();
    tests++; if (dif.dma_abort_o !== 1'b1 || dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL ab_en got abort=%b req=%b exp abort=1 req=0", dif.dma_abort_o, dif.dma_req_o); end
    tx_elem = 7'd40; rx_elem = 7'd0; tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    en = 1; burst_len = 5'd2; tx_th = 5'd4; tx_elem = 7'd0; rx_th = 5'd31; rx_elem = 7'd0;
    tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL sim_req got %b exp 1", dif.dma_req_o); end
    dif.dma_ack_i = 1; flush = 1; tick(); dif.dma_ack_i = 0; flush = 0;
    tests++; if (dif.dma_abort_o !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL sim_ack_flush got abort=%b busy=%b exp abort=1 busy=0", dif.dma_abort_o, busy); end
    tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL sim_rereq got %b exp 1", dif.dma_req_o); end
    tx_elem = 7'd40;
    dif.dma_beat_i = 1; tick();
    tests++; if (dif.dma_req_o !== 1'b1) begin fails++; $display("FAIL sim_beat_in_req got %b exp 1", dif.dma_req_o); end
    dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
    tests++; if (dif.dma_req_o !== 1'b0) begin fails++; $display("FAIL sim_ack got %b exp 0", dif.dma_req_o); end
    tick();
    tests++; if (dif.dma_done_o !== 1'b0) begin fails++; $display("FAIL sim_beat1 got %b exp 0", dif.dma_done_o); end
    tick(); dif.dma_beat_i = 0;
    tests++; if (dif.dma_done_o !== 1'b1) begin fails++; $display("FAIL sim_beat2 got %b exp 1", dif.dma_done_o); end
    tick();
  endtask

  task automatic test_irq();
    apply_reset();
    en = 1; txie = 1; tx_elem = 7'd2; tx_th = 5'd5;
    tick();
    tests++; if (tx_irq !== 1'b1) begin fails++; $display("FAIL irq_tx_set got %b exp 1", tx_irq); end
    txie = 0; tick();
    tests++; if (tx_irq !== 1'b0) begin fails++; $display("FAIL irq_tx_clr got %b exp 0", tx_irq); end
    rxie = 1; rx_elem = 7'd10; rx_th = 5'd5; tick();
    tests++; if (rx_irq !== 1'b1) begin fails++; $display("FAIL irq_rx_set got %b exp 1", rx_irq); end
    en = 0; tick();
    tests++; if (rx_irq !== 1'b0) begin fails++; $display("FAIL irq_rx_en got %b exp 0", rx_irq); end
    rxie = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 1; txie = 1; burst_len = 5'd8; tx_th = 5'd4; tx_elem = 7'd0; rx_th = 5'd31; rx_elem = 7'd0;
    tick();
    dif.dma_ack_i = 1; tick(); dif.dma_ack_i = 0;
    dif.dma_beat_i = 1; tick(); tick();
    tests++; if (busy !== 1'b1 || tx_irq !== 1'b1) begin fails++; $display("FAIL rmid_pre got busy=%b irq=%b exp 1 1", busy, tx_irq); end
    #2; rst = 1; #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tests++; if (dif.dma_len_o !== 5'd0) begin fails++; $display("FAIL rmid_len got %0d exp 0", dif.dma_len_o); end
    tests++; if (tx_irq !== 1'b0) begin fails++; $display("FAIL rmid_irq got %b exp 0", tx_irq); end
    tests++; if ({dif.dma_req_o, dif.dma_done_o, dif.dma_abort_o} !== 3'b000) begin fails++; $display("FAIL rmid_pulses got %b exp 000", {dif.dma_req_o, dif.dma_done_o, dif.dma_abort_o}); end
    #1; rst = 0;
    dif.dma_beat_i = 0; en = 0; txie = 0;
    tick();
    tests++; if (dif.dma_done_o !== 1'b0 || dif.dma_abort_o !== 1'b0) begin fails++; $display("FAIL rmid_after got done=%b abort=%b exp 0 0", dif.dma_done_o, dif.dma_abort_o); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_tx();
    test_round_robin();
    test_boundary();
    test_abort();
    test_simultaneous();
    test_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
